branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/bp_pkg.sv | 19 +
 rtl/bp_if.sv | 35 +++
 rtl/bp_ras.sv | 48 ++++
 rtl/branch_predictor.sv | 126 ++++++++++++
 tb/tb_branch_predictor.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor: FSM states, counter
// init value and the BTB entry layout.
package bp_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } bp_state_e;

  localparam int CTR_INIT = 1;

  // Tag is kept at full width; unused upper bits are zero for any IDX_W.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
  } btb_entry_t;

endpackage

// File: rtl/bp_if.sv
// Fetch/predict/resolve/statistics bundle between the pipeline (master) and
// the branch predictor (slave).
interface bp_if #(
  parameter int HIST_W = 2
);
  logic              ready;
  logic [31:0]       f_pc;
  logic              f_is_jump;
  logic              f_is_ret;
  logic [31:0]       pred_dest;
  logic [HIST_W-1:0] pred_hist;
  logic              u_valid;
  logic [31:0]       u_pc;
  logic [31:0]       u_dest;
  logic              u_taken;
  logic              u_mispred;
  logic [HIST_W-1:0] u_hist;
  logic              u_is_call;
  logic              u_is_ret;
  logic [31:0]       stat_total;
  logic [31:0]       stat_hit;
  logic [31:0]       stat_miss;

  modport master (
    output f_pc, f_is_jump, f_is_ret,
    output u_valid, u_pc, u_dest, u_taken, u_mispred, u_hist, u_is_call, u_is_ret,
    input  ready, pred_dest, pred_hist, stat_total, stat_hit, stat_miss
  );

  modport slave (
    input  f_pc, f_is_jump, f_is_ret,
    input  u_valid, u_pc, u_dest, u_taken, u_mispred, u_hist, u_is_call, u_is_ret,
    output ready, pred_dest, pred_hist, stat_total, stat_hit, stat_miss
  );
endinterface

// File: rtl/bp_ras.sv
// Circular return-address stack: overflow overwrites the oldest entry,
// underflow is ignored, push+pop together replaces the top.
module bp_ras #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           push_data,
  output logic [W-1:0]           top,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  stack [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_top;
  logic          replace;

  // ptr is the next free slot, so the top lives one below it.
  assign ptr_top = ptr - 1'b1;
  assign top     = stack[ptr_top];
  assign replace = push & pop & (count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (!replace) begin
      if (push) begin
        ptr <= ptr + 1'b1;
        if (count != CW'(DEPTH)) count <= count + 1'b1;
      end else if (pop && count != '0) begin
        ptr   <= ptr_top;
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (replace)   stack[ptr_top] <= push_data;
    else if (push) stack[ptr]     <= push_data;
  end

endmodule

// File: rtl/branch_predictor.sv
// Gshare-style predictor: per-entry history-indexed counters plus a tagged BTB,
// cleared by an INIT sweep after reset. Optional return stack under BP_RAS_EN.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_W     = 8,
  parameter int HIST_W    = 2,
  parameter int CTR_W     = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  bp_if.slave  bp
);
  localparam int N = 1 << IDX_W;
  localparam int H = 1 << HIST_W;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  function automatic logic [CTR_W-1:0] ctr_sat_step(input logic [CTR_W-1:0] c,
                                                    input logic up);
    if (up) return (c == CTR_MAX) ? c : c + 1'b1;
    return (c == '0) ? c : c - 1'b1;
  endfunction

  bp_state_e         state, state_nxt;
  logic [IDX_W-1:0]  sweep;
  logic [HIST_W-1:0] ghr, ghr_nxt;
  logic [CTR_W-1:0]  bht [N][H];
  btb_entry_t        btb [N];
  logic [31:0]       stat_total, stat_hit, stat_miss;
  logic              run, upd;
  logic [IDX_W-1:0]  f_idx, u_idx;
  logic [31:0]       f_tag, u_tag, pc_inc, bht_dest, run_dest;
  logic [CTR_W-1:0]  f_ctr;
  logic              btb_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
      sweep <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) sweep <= sweep + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && (&sweep)) state_nxt = ST_RUN;
  end

  assign run      = (state == ST_RUN);
  assign upd      = run & bp.u_valid;
  assign bp.ready = run;

  assign u_idx = bp.u_pc[IDX_W-1:0];
  assign u_tag = bp.u_pc >> IDX_W;

  // Tables carry no reset; the INIT sweep owns them until RUN.
  always_ff @(posedge clk) begin
    if (!run) begin
      for (int h = 0; h < H; h++) bht[sweep][h] <= CTR_W'(CTR_INIT);
      btb[sweep].valid <= 1'b0;
    end else if (bp.u_valid) begin
      bht[u_idx][bp.u_hist] <= ctr_sat_step(bht[u_idx][bp.u_hist], bp.u_taken);
      if (bp.u_taken) btb[u_idx] <= '{valid: 1'b1, tag: u_tag, target: bp.u_dest};
    end
  end

  if (HIST_W == 1) begin : g_ghr1
    assign ghr_nxt = bp.u_taken;
  end else begin : g_ghrn
    assign ghr_nxt = {bp.u_hist[HIST_W-2:0], bp.u_taken};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr        <= '0;
      stat_total <= '0;
      stat_hit   <= '0;
      stat_miss  <= '0;
    end else if (upd) begin
      ghr        <= ghr_nxt;
      stat_total <= stat_total + 32'd1;
      if (bp.u_mispred) stat_miss <= stat_miss + 32'd1;
      else              stat_hit  <= stat_hit + 32'd1;
    end
  end

  assign bp.stat_total = stat_total;
  assign bp.stat_hit   = stat_hit;
  assign bp.stat_miss  = stat_miss;

  assign f_idx    = bp.f_pc[IDX_W-1:0];
  assign f_tag    = bp.f_pc >> IDX_W;
  assign pc_inc   = bp.f_pc + 32'd1;
  assign f_ctr    = bht[f_idx][ghr];
  assign btb_hit  = btb[f_idx].valid && (btb[f_idx].tag == f_tag);
  assign bht_dest = (bp.f_is_jump && f_ctr[CTR_W-1] && btb_hit) ? btb[f_idx].target : pc_inc;

`ifdef BP_RAS_EN
  logic [31:0]                 ras_top;
  logic [$clog2(RAS_DEPTH):0]  ras_count;

  bp_ras #(.DEPTH(RAS_DEPTH), .W(32)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (upd & bp.u_is_call),
    .pop       (upd & bp.u_is_ret),
    .push_data (bp.u_pc + 32'd1),
    .top       (ras_top),
    .count     (ras_count)
  );

  assign run_dest = (bp.f_is_ret && ras_count != '0) ? ras_top : bht_dest;
`else
  localparam int UNUSED_RAS_DEPTH = RAS_DEPTH;
  logic unused_ras;
  assign unused_ras = ^{bp.f_is_ret, bp.u_is_call, bp.u_is_ret};
  assign run_dest   = bht_dest;
`endif

  assign bp.pred_dest = run ? run_dest : pc_inc;
  assign bp.pred_hist = run ? ghr : '0;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: init sweep, BTB/counter behaviour,
// saturation, statistics, reset during INIT, and the return stack under BP_RAS_EN.
module tb_branch_predictor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bp_if #(.HIST_W(2)) bus ();

  branch_predictor #(
    .IDX_W(8), .HIST_W(2), .CTR_W(2), .RAS_DEPTH(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_total = 0;
  int exp_hit = 0;
  int exp_miss = 0;
  int n_cyc;
  logic [31:0] t0;

  logic [31:0] ns_exp [5] = '{32'h40, 32'h40, 32'h11, 32'h11, 32'h11};
  logic        ns_mis [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.f_pc      = '0;
    bus.f_is_jump = 1'b0;
    bus.f_is_ret  = 1'b0;
    bus.u_valid   = 1'b0;
    bus.u_pc      = '0;
    bus.u_dest    = '0;
    bus.u_taken   = 1'b0;
    bus.u_mispred = 1'b0;
    bus.u_hist    = '0;
    bus.u_is_call = 1'b0;
    bus.u_is_ret  = 1'b0;
  endtask

  task automatic predict(input logic [31:0] pc, input logic jump, input logic ret,
                         input logic [31:0] exp, input string tag);
    bus.f_pc      = pc;
    bus.f_is_jump = jump;
    bus.f_is_ret  = ret;
    #1;
    check(tag, bus.pred_dest, exp);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [31:0] dest, input logic [1:0] hist,
                         input logic taken, input logic mis, input logic call, input logic ret);
    bus.u_valid   = 1'b1;
    bus.u_pc      = pc;
    bus.u_dest    = dest;
    bus.u_hist    = hist;
    bus.u_taken   = taken;
    bus.u_mispred = mis;
    bus.u_is_call = call;
    bus.u_is_ret  = ret;
    @(posedge clk);
    #1;
    bus.u_valid   = 1'b0;
    bus.u_is_call = 1'b0;
    bus.u_is_ret  = 1'b0;
    exp_total++;
    if (mis) exp_miss++;
    else     exp_hit++;
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_total"}, bus.stat_total, exp_total);
    check({tag, "_hit"},   bus.stat_hit,   exp_hit);
    check({tag, "_miss"},  bus.stat_miss,  exp_miss);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.ready !== 1'b1 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", bus.ready, 0);
    check("rst_total", bus.stat_total, 0);
    check("rst_hit", bus.stat_hit, 0);
    check("rst_miss", bus.stat_miss, 0);
    predict(32'd5, 1'b1, 1'b0, 32'd6, "init_pred");
    check("init_hist", bus.pred_hist, 0);

    // A resolve presented throughout INIT must leave no trace.
    bus.u_valid = 1'b1; bus.u_pc = 32'd5; bus.u_dest = 32'h99;
    bus.u_taken = 1'b1; bus.u_hist = 2'b11; bus.u_mispred = 1'b1;
    rst = 1'b0;
    wait_ready(n_cyc);
    bus.u_valid = 1'b0;
    check("ready_latency", n_cyc, 256);
    check("ready_high", bus.ready, 1);
    check("init_ignored_total", bus.stat_total, 0);
    check("init_ignored_hist", bus.pred_hist, 0);
    predict(32'd5, 1'b1, 1'b0, 32'd6, "run_btb_empty");

    // Train pc 0x10 at history 0: counter 1 -> 2 -> 3 -> 3.
    resolve(32'h10, 32'h40, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    resolve(32'h10, 32'h40, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    resolve(32'h10, 32'h40, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ghr_after_taken", bus.pred_hist, 1);
    predict(32'h10, 1'b1, 1'b0, 32'h11, "ghr1_weak_ctr");
    resolve(32'h20, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ghr_back_to_0", bus.pred_hist, 0);
    predict(32'h10, 1'b1, 1'b0, 32'h40, "btb_hit");
    predict(32'h10, 1'b0, 1'b0, 32'h11, "not_jump");
    predict(32'h110, 1'b1, 1'b0, 32'h111, "tag_miss");
    check_stats("stats_a");

    // Five not-taken resolves while predicting the same entry in the same cycle.
    t0 = bus.stat_total;
    for (int i = 0; i < 5; i++) begin
      predict(32'h10, 1'b1, 1'b0, ns_exp[i], $sformatf("same_cycle_%0d", i));
      resolve(32'h10, 32'h40, 2'b00, 1'b0, ns_mis[i], 1'b0, 1'b0);
    end
    check("five_total_delta", bus.stat_total - t0, 5);
    check_stats("stats_b");

    // Counter held at 0: one taken reaches 1 (weak), a second reaches 2.
    resolve(32'h10, 32'h40, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    resolve(32'h20, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    predict(32'h10, 1'b1, 1'b0, 32'h11, "sat_low");
    resolve(32'h10, 32'h40, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    resolve(32'h20, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    predict(32'h10, 1'b1, 1'b0, 32'h40, "recover");
    check_stats("stats_c");

`ifdef BP_RAS_EN
    for (int i = 1; i <= 5; i++)
      resolve(32'(i), 32'h50, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    predict(32'h30, 1'b1, 1'b1, 32'h6, "ras_top");
    for (int k = 0; k < 3; k++) begin
      resolve(32'h30, 32'h77, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
      predict(32'h30, 1'b1, 1'b1, 32'(5 - k), $sformatf("ras_pop_%0d", k));
    end
    resolve(32'h30, 32'h77, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    predict(32'h30, 1'b1, 1'b1, 32'h31, "ras_empty_ghr1");
    resolve(32'h20, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    predict(32'h30, 1'b1, 1'b1, 32'h77, "ras_empty_btb");
    check_stats("stats_ras");
`else
    predict(32'h110, 1'b1, 1'b1, 32'h111, "ret_ignored");
`endif

    // Reset, then interrupt the sweep at entry 100.
    bus.f_is_ret = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("mid_sweep_ready", bus.ready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rerst_total", bus.stat_total, 0);
    wait_ready(n_cyc);
    check("rerst_latency", n_cyc, 256);
    check("rerst_hist", bus.pred_hist, 0);
    predict(32'h10, 1'b1, 1'b0, 32'h11, "btb_cleared");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
